probe_led_sequencer: RTL and testbench
======================================

// Module: probe_led_sequencer
// PURPOSE
//  Downstream consumer of the core's debug probe bus. Captures one probe word
//  (e.g. PC, ALU result, memory read value) on a strobe and plays it out on
//  the 4 board LEDs one nibble at a time, LSB nibble first, with a fixed dwell
//  per nibble and a blank gap between words. Replaces the static low-nibble
//  LED tap in the processor top level.
// PARAMETERS
//  DATA_WIDTH    32        probe word width; must be a multiple of 4, >= 8
//  DWELL_CYCLES  25000000  clk cycles each nibble, and the gap, are held (>= 2)
//  DROP_WIDTH    8         width of the saturating dropped-sample counter
// PORTS
//  clk           in   1           system clock
//  reset         in   1           asynchronous, active-low reset
//  sample_valid  in   1           probe word offered this cycle
//  sample_data   in   DATA_WIDTH  probe word
//  sample_ready  out  1           block can accept a word (IDLE only)
//  led_nibble    out  4           nibble currently displayed
//  led_frame     out  1           high while nibble 0 is displayed
//  busy          out  1           high in SHOW or GAP
//  drop_count    out  DROP_WIDTH  offered words not accepted; saturates
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, sample_ready=1,
//   led_nibble=0, led_frame=0, busy=0, drop_count=0, internal word/idx/dwell=0.
//  All outputs registered; no combinational path from input to output.
//  NIBBLES = DATA_WIDTH/4; idx width = clog2(NIBBLES); dwell width =
//   clog2(DWELL_CYCLES).
//  States:
//   IDLE: leds 0. sample_valid=1 (ready=1) -> latch sample_data, idx=0,
//    dwell=0, -> SHOW. Next cycle: ready=0, busy=1, led_nibble=word[3:0],
//    led_frame=1 (1-cycle capture-to-LED latency).
//   SHOW: led_nibble=word[4*idx+:4]; led_frame=(idx==0). dwell increments
//    each cycle; at dwell==DWELL_CYCLES-1: dwell=0, and if idx==NIBBLES-1
//    -> GAP (leds 0), else idx+1. Each nibble held exactly DWELL_CYCLES cycles.
//   GAP: leds 0, busy=1, ready=0 for DWELL_CYCLES cycles, then -> IDLE with
//    ready=1 in the following cycle.
//  Handshake: transfer iff sample_valid & sample_ready. Latched word is never
//   altered by sample_data changes mid-playback.
//  Drop: sample_valid=1 while sample_ready=0 -> drop_count+1 per cycle,
//   holding at 2^DROP_WIDTH-1 (no wrap). Cleared only by reset.
//  Simultaneous: valid arriving in the same cycle GAP ends is dropped
//   (ready still 0); accepted only from the first IDLE cycle.
//  Reset mid-playback: immediate return to reset values; word discarded.
//  Total occupancy per accepted word: (NIBBLES+1)*DWELL_CYCLES cycles + 1.
// TESTING (DATA_WIDTH=32, DWELL_CYCLES=4, DROP_WIDTH=8)
//  1 Reset asserted mid-SHOW -> all outputs at reset values same cycle,
//    held until release; ready=1 first cycle after release.
//  2 Offer 0x8765_4321 in IDLE -> led_nibble 1,2,3,4,5,6,7,8 each for 4
//    cycles, led_frame=1 only during nibble 1, then 4 cycles of 0, ready=1
//    after 37 cycles total.
//  3 Hold sample_valid=1 with 0xFFFF_FFFF after acceptance of 0x0000_000A ->
//    display A,0,0..; drop_count=36 when ready returns; next word
//    0xFFFF_FFFF accepted on the first IDLE cycle.
//  4 Keep valid high over 300 busy cycles -> drop_count saturates at 255.
//  5 Change sample_data every cycle during SHOW -> displayed nibbles stay
//    those of the latched word.
//  6 Valid pulse exactly on last GAP cycle -> not accepted, drop_count+1,
//    state returns to IDLE with leds 0.

Source files
------------

// File: rtl/probe_led_sequencer.sv
// Latches one probe word and shows it on 4 LEDs, LSB nibble first, then a blank gap.
// Capture to first nibble takes 1 cycle. The block accepts a word only in IDLE, and offers refused while busy are counted.
module probe_led_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int DWELL_CYCLES = 25000000,
  parameter int DROP_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  sample_ready,
  output logic [3:0]            led_nibble,
  output logic                  led_frame,
  output logic                  busy,
  output logic [DROP_WIDTH-1:0] drop_count
);

  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int IW      = $clog2(NIBBLES);
  localparam int DW      = $clog2(DWELL_CYCLES);

  localparam logic [IW-1:0] IDX_LAST   = IW'(NIBBLES - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] word;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_inc;
  logic [DW-1:0]         dwell;
  logic                  dwell_done;
  logic                  drop_sat;

  assign idx_inc    = idx + 1'b1;
  assign dwell_done = (dwell == DWELL_LAST);
  assign drop_sat   = &drop_count;

  // Outputs are loaded alongside the state change, so the LEDs always reflect the current state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      word         <= '0;
      idx          <= '0;
      dwell        <= '0;
      sample_ready <= 1'b1;
      led_nibble   <= 4'h0;
      led_frame    <= 1'b0;
      busy         <= 1'b0;
      drop_count   <= '0;
    end else begin
      if (sample_valid && !sample_ready && !drop_sat) begin
        drop_count <= drop_count + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (sample_valid && sample_ready) begin
            word         <= sample_data;
            idx          <= '0;
            dwell        <= '0;
            state        <= S_SHOW;
            sample_ready <= 1'b0;
            busy         <= 1'b1;
            led_nibble   <= sample_data[3:0];
            led_frame    <= 1'b1;
          end
        end

        S_SHOW: begin
          if (dwell_done) begin
            dwell     <= '0;
            led_frame <= 1'b0;
            if (idx == IDX_LAST) begin
              state      <= S_GAP;
              led_nibble <= 4'h0;
            end else begin
              idx        <= idx_inc;
              led_nibble <= word[{idx_inc, 2'b00} +: 4];
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end

        S_GAP: begin
          if (dwell_done) begin
            dwell        <= '0;
            state        <= S_IDLE;
            busy         <= 1'b0;
            sample_ready <= 1'b1;
          end else begin
            dwell <= dwell + 1'b1;
          end
        end

        default: begin
          state        <= S_IDLE;
          dwell        <= '0;
          sample_ready <= 1'b1;
          busy         <= 1'b0;
          led_nibble   <= 4'h0;
          led_frame    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_probe_led_sequencer.sv
// Directed bench for probe_led_sequencer: expected per-cycle LED/handshake states are queued, and a negedge monitor checks them.
module tb_probe_led_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        sample_ready;
  logic [3:0]  led_nibble;
  logic        led_frame;
  logic        busy;
  logic [7:0]  drop_count;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] nib;
    logic       frame;
    logic       busy;
    logic       rdy;
    logic       chk_drop;
    logic [7:0] drop;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] drop_tbl [9];
  int s;

  probe_led_sequencer #(
    .DATA_WIDTH  (32),
    .DWELL_CYCLES(4),
    .DROP_WIDTH  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .sample_ready(sample_ready),
    .led_nibble  (led_nibble),
    .led_frame   (led_frame),
    .busy        (busy),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int c, input logic [3:0] n, input logic f, input logic b,
                          input logic r, input logic cd, input logic [7:0] d, input string nm);
    exp_t e;
    e.cyc = c; e.nib = n; e.frame = f; e.busy = b; e.rdy = r;
    e.chk_drop = cd; e.drop = d; e.name = nm;
    exp_q.push_back(e);
  endtask

  // A word captured at edge s shows 8 nibbles x 4 cycles, 4 blank cycles, then IDLE at s+36.
  task automatic push_word(input logic [31:0] w, input int st, input logic [7:0] d_idle, input string nm);
    logic [31:0] wv;
    wv = w;
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 4; k++)
        push_exp(st + 4*n + k, wv[4*n +: 4], (n == 0), 1'b1, 1'b0, 1'b0, 8'd0, nm);
    for (int k = 0; k < 4; k++)
      push_exp(st + 32 + k, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, {nm, "_gap"});
    push_exp(st + 36, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, d_idle, {nm, "_idle"});
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic offer(input logic [31:0] w, input logic [7:0] d_idle, input string nm, output int s_out);
    sample_data  = w;
    sample_valid = 1'b1;
    s_out = cyc + 1;
    push_word(w, s_out, d_idle, nm);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (mon_e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: check for cycle %0d skipped, now cycle %0d", mon_e.name, mon_e.cyc, cyc);
      end else if (led_nibble !== mon_e.nib || led_frame !== mon_e.frame || busy !== mon_e.busy ||
                   sample_ready !== mon_e.rdy || (mon_e.chk_drop && drop_count !== mon_e.drop)) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: got nib=%h frame=%b busy=%b ready=%b drop=%0d, want nib=%h frame=%b busy=%b ready=%b drop=%0d (drop checked=%b)",
                 mon_e.name, cyc, led_nibble, led_frame, busy, sample_ready, drop_count,
                 mon_e.nib, mon_e.frame, mon_e.busy, mon_e.rdy, mon_e.drop, mon_e.chk_drop);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks still pending", exp_q.size());
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    drop_tbl = '{8'd73, 8'd109, 8'd145, 8'd181, 8'd217, 8'd253, 8'd255, 8'd255, 8'd255};
    reset        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = 32'h0;

    // Power-on reset values, then release away from the clock edge.
    for (int c = 1; c <= 3; c++) push_exp(c, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, "reset_init");
    wait_cyc(3);
    reset = 1'b1;
    push_exp(4, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, "post_release");
    wait_cyc(4);

    // Basic playback: nibbles 1..8, frame on the first, gap, IDLE 37 cycles after acceptance.
    offer(32'h8765_4321, 8'd0, "word_87654321", s);
    wait_cyc(s + 36);

    // Valid held through a whole playback: 36 drops, next word taken on the first IDLE cycle.
    sample_data  = 32'h0000_000A;
    sample_valid = 1'b1;
    s = cyc + 1;
    push_word(32'h0000_000A, s, 8'd36, "hold_A");
    @(posedge clk);
    #1;
    sample_data = 32'hFFFF_FFFF;
    wait_cyc(s + 36);
    s = cyc + 1;
    push_word(32'hFFFF_FFFF, s, 8'd36, "hold_F");
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    wait_cyc(s + 36);

    // A valid pulse on the last GAP cycle is dropped, and the block settles in IDLE.
    offer(32'h3C5A_96F0, 8'd37, "gap_edge", s);
    wait_cyc(s + 35);
    sample_data  = 32'hDEAD_BEEF;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    push_exp(s + 37, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd37, "gap_edge_stay_idle");
    wait_cyc(s + 37);

    // sample_data churns during playback; the latched word must still be shown.
    offer(32'h1357_9BDF, 8'd37, "data_churn", s);
    while (cyc < s + 36) begin
      @(posedge clk);
      #1;
      sample_data = $urandom;
    end

    // Valid held across 9 back-to-back words (324 busy cycles) drives the counter into saturation.
    sample_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      sample_data = 32'h0F1E_2D30 + 32'(k);
      s = cyc + 1;
      push_word(sample_data, s, drop_tbl[k], "saturate");
      wait_cyc(s + 36);
    end
    sample_valid = 1'b0;

    // Reset in the middle of SHOW: reset values at once, held until release, then normal operation.
    offer(32'h2468_ACE0, 8'd255, "mid_reset", s);
    wait_cyc(s + 5);
    #1;
    reset = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 4; c++) push_exp(s + 5 + c, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, "in_reset");
    wait_cyc(s + 8);
    reset = 1'b1;
    push_exp(s + 9, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, "after_reset");
    wait_cyc(s + 9);
    offer(32'h0000_00F1, 8'd0, "post_reset_word", s);
    wait_cyc(s + 38);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_checks: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
